uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that deserialises the frame the link transmitter emits: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
- Oversamples the serial line at the system clock, centre-samples each bit and checks parity and stop bit.
- Presents each byte on a valid/ack holding register with error and overrun flags.
- Sits between the board RX pin and the command/packet decoder.

Parameters:
CLKS_PER_BIT, 4, system clocks per bit period (24 MHz / 6 Mbaud); legal range >= 4.
PARITY, 0, 0 = even (parity bit = XOR of data), 1 = odd (parity bit = ~XOR of data).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
rx  input  1  serial line; asynchronous to clk; idles high.
rx_ack  input  1  consumer acknowledge; clears rx_valid and overrun.
rx_data  output  8  received byte; held until the next completed frame.
rx_valid  output  1  level; high from frame completion until acked.
parity_err  output  1  parity mismatch on the byte in rx_data.
frame_err  output  1  stop bit sampled 0 for the byte in rx_data.
overrun  output  1  sticky; a frame completed while rx_valid was still high.
rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset (reset low, async):
- All outputs 0, rx_data 0, FSM in IDLE, counters 0.
- Synchroniser flops set to 1.
- A mid-frame reset abandons the frame with no output.

Input path and counters:
- rx passes through a 2-flop synchroniser giving rx_s; that is 2 clk of latency.
- HALF = CLKS_PER_BIT/2, integer division.
- cnt is $clog2(CLKS_PER_BIT) bits wide; bit_idx is 3 bits wide.

FSM states:
- IDLE: when rx_s==0, set cnt=0 and go to START.
- START: cnt increments each clk. At cnt==HALF-1, sample rx_s:
  - if 0, set cnt=0, bit_idx=0 and go to DATA;
  - if 1, treat as a glitch and go to IDLE with no flags changed.
- DATA: cnt increments. At cnt==CLKS_PER_BIT-1, shift rx_s into the shift register MSB-first-in (right shift) and set cnt=0.
  - When bit_idx==7, go to PARITY; otherwise bit_idx+1.
- PARITY: at cnt==CLKS_PER_BIT-1, latch p_bad = rx_s XOR (PARITY ? ~^shift : ^shift), set cnt=0 and go to STOP.
- STOP: at cnt==CLKS_PER_BIT-1, commit the frame (below).
  - If rx_s==1, go to IDLE.
  - If rx_s==0, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line from retriggering.

Commit (one cycle, registered; outputs visible the clk after the stop-bit sample):
- rx_data <= shift; parity_err <= p_bad; frame_err <= ~rx_s; rx_valid <= 1.
- overrun <= overrun | (rx_valid & ~rx_ack).
- A byte is always delivered, even with errors.

rx_ack rules:
- rx_ack while rx_valid clears rx_valid and overrun next clk.
- If rx_ack coincides with a commit, the commit wins: rx_valid stays 1 with the new data, and overrun is not set by that commit.
- rx_ack while rx_valid==0 is ignored.

Timing:
- Return to IDLE happens half a bit before the nominal stop-bit end, so back-to-back frames are accepted.
- rx_busy = (state != IDLE), combinational from state.

Test Plan:
- CLKS_PER_BIT=4, PARITY=0; drive frame 0xA5 (parity 0, stop 1) at 4 clk/bit, no ack -> rx_valid=1, rx_data=0xA5, parity_err=0, frame_err=0, overrun=0, ~2 clk after the stop-bit centre; stays valid until rx_ack pulse, then rx_valid=0.
- Frame 0x01 with parity bit 0 (even requires 1) -> rx_data=0x01, parity_err=1, frame_err=0. Repeat with PARITY=1 and parity bit 0 -> parity_err=0.
- rx low for 1 clk then high -> no rx_valid; rx_busy high for <= HALF+1 clk, then back to IDLE.
- Frame 0x3C with stop bit 0 and line held low 20 clk -> rx_valid=1, rx_data=0x3C, frame_err=1; no further frame until rx rises. A subsequent valid frame 0x55 is received correctly.
- Back-to-back frames 0x11 then 0x22 with no ack -> rx_data=0x22, overrun=1; rx_ack clears both. Repeat with rx_ack asserted exactly on the second commit cycle -> rx_valid=1, rx_data=0x22, overrun=0.
- Assert reset mid-DATA of 0x7E -> all outputs 0 immediately (async); after release the remaining bits are not decoded as a byte; next full frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver.
// Frame: start(0), 8 data bits LSB first, parity bit, stop(1).
// Bits are centre-sampled and the byte is presented on a valid/ack
// holding register with parity, framing and overrun flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          p_bad;
    logic          rx_meta;
    logic          rx_s;

    // Parity bit the transmitter should have sent for a given byte.
    function automatic logic expected_parity(input logic [7:0] d);
        return (PARITY != 0) ? ~(^d) : ^d;
    endfunction

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with the output holding register; a commit in STOP
    // is written after the ack clear so it takes priority over it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            p_bad      <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt   <= '0;
                        state <= START;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        if (!rx_s) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= DATA;
                        end else begin
                            // Too short to be a start bit: treat as a glitch.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == LAST) begin
                        shift <= {rx_s, shift[7:1]};
                        cnt   <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= PAR;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PAR: begin
                    if (cnt == LAST) begin
                        p_bad <= rx_s ^ expected_parity(shift);
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == LAST) begin
                        // Deliver the byte even when it carries errors.
                        rx_data    <= shift;
                        parity_err <= p_bad;
                        frame_err  <= ~rx_s;
                        rx_valid   <= 1'b1;
                        overrun    <= overrun | (rx_valid & ~rx_ack);
                        cnt        <= '0;
                        state      <= rx_s ? IDLE : BRK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BRK: begin
                    // A line held low must rise before a new start is seen.
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with an even-parity and an
// odd-parity instance sharing the same serial line and acknowledge.
module tb_uart_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx_ack;

    logic [7:0] e_data, o_data;
    logic       e_valid, o_valid;
    logic       e_perr, o_perr;
    logic       e_ferr, o_ferr;
    logic       e_ovr, o_ovr;
    logic       e_busy, o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY(0)) u_even (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_ack     (rx_ack),
        .rx_data    (e_data),
        .rx_valid   (e_valid),
        .parity_err (e_perr),
        .frame_err  (e_ferr),
        .overrun    (e_ovr),
        .rx_busy    (e_busy)
    );

    uart_rx #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_odd (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rx_ack     (rx_ack),
        .rx_data    (o_data),
        .rx_valid   (o_valid),
        .parity_err (o_perr),
        .frame_err  (o_ferr),
        .overrun    (o_ovr),
        .rx_busy    (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pbit;
        logic       stopb;
        logic       perr_e;
        logic       perr_o;
        logic       ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // All serial driving happens on falling edges.
    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        send_bit(stopb);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    initial begin
        int busy_cnt;

        // data, parity bit, stop bit, even perr, odd perr, frame err
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rx     = 1'b1;
        rx_ack = 1'b0;
        reset  = 1'b1;
        #3 reset = 1'b0;
        #1;
        check("reset_valid", e_valid, 1'b0);
        check("reset_data", e_data, 8'h00);
        check("reset_flags", {e_perr, e_ferr, e_ovr, e_busy}, 4'b0000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Table-driven frames: each is checked, held, then acknowledged.
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].d, vecs[v].pbit, vecs[v].stopb);
            rx = 1'b1;
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_valid", v), e_valid, 1'b1);
            check($sformatf("v%0d_data", v), e_data, vecs[v].d);
            check($sformatf("v%0d_perr_even", v), e_perr, vecs[v].perr_e);
            check($sformatf("v%0d_perr_odd", v), o_perr, vecs[v].perr_o);
            check($sformatf("v%0d_ferr", v), e_ferr, vecs[v].ferr);
            check($sformatf("v%0d_ovr", v), e_ovr, 1'b0);
            repeat (8) @(negedge clk);
            check($sformatf("v%0d_held", v), e_valid, 1'b1);
            ack_pulse();
            check($sformatf("v%0d_acked", v), {e_valid, o_valid}, 2'b00);
            repeat (4) @(negedge clk);
        end

        // One-clock glitch: short busy window, no byte.
        busy_cnt = 0;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (e_busy) busy_cnt++;
        end
        check("glitch_busy_seen", (busy_cnt >= 1 && busy_cnt <= 3), 1'b1);
        check("glitch_no_valid", e_valid, 1'b0);
        check("glitch_idle", e_busy, 1'b0);

        // Stop bit 0 with the line held low for 20 clocks in total.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (16) @(negedge clk);
        check("brk_valid", e_valid, 1'b1);
        check("brk_data", e_data, 8'h3C);
        check("brk_ferr", e_ferr, 1'b1);
        check("brk_perr", e_perr, 1'b0);
        check("brk_busy", e_busy, 1'b1);
        ack_pulse();
        repeat (8) @(negedge clk);
        check("brk_no_retrigger", e_valid, 1'b0);
        check("brk_still_busy", e_busy, 1'b1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("brk_released", {e_busy, e_valid}, 2'b00);
        send_frame(8'h55, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("after_brk_valid", e_valid, 1'b1);
        check("after_brk_data", e_data, 8'h55);
        check("after_brk_flags", {e_perr, e_ferr, e_ovr}, 3'b000);
        ack_pulse();
        repeat (4) @(negedge clk);

        // Back-to-back frames without ack set overrun.
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("ovr_data", e_data, 8'h22);
        check("ovr_valid", e_valid, 1'b1);
        check("ovr_flag", e_ovr, 1'b1);
        ack_pulse();
        check("ovr_ack_valid", e_valid, 1'b0);
        check("ovr_ack_flag", e_ovr, 1'b0);
        repeat (4) @(negedge clk);

        // Ack on the exact second commit cycle: commit wins, no overrun.
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        check("coinc_valid", e_valid, 1'b1);
        check("coinc_data", e_data, 8'h22);
        check("coinc_ovr", e_ovr, 1'b0);
        repeat (4) @(negedge clk);

        // Reset in the middle of the data bits of 0x7E.
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        #2 reset = 1'b0;
        #1;
        check("midrst_valid", e_valid, 1'b0);
        check("midrst_data", e_data, 8'h00);
        check("midrst_flags", {e_perr, e_ferr, e_ovr, e_busy}, 4'b0000);
        @(negedge clk);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_byte", e_valid, 1'b0);
        check("midrst_idle", e_busy, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("post_rst_valid", e_valid, 1'b1);
        check("post_rst_data", e_data, 8'h81);
        check("post_rst_flags", {e_perr, e_ferr, e_ovr}, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
